// File: rtl/alu_packet_parser.sv
// UART byte-stream packet parser: header decode, echo pass-through and 32-bit operand assembly for the ALU.
// Optional build macro ALU_PARSER_ERR_CHECK_EN enables err_o and length/opcode error checking.
module alu_packet_parser #(
  parameter logic [15:0] MAX_PAYLOAD = 16'd1020
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        operand_first_o,
  output logic        operand_last_o,
  output logic        err_o
);

  // state   | meaning
  // IDLE    | waiting for opcode byte
  // RSVD    | skipping reserved header byte
  // LEN_LO  | capturing length bits [7:0]
  // LEN_HI  | capturing length bits [15:8], dispatching on opcode
  // ECHO    | payload bytes pass straight through to the transmitter
  // COLLECT | assembling 4 payload bytes into an operand
  // EMIT    | presenting an operand until the ALU accepts it
  // DRAIN   | discarding remaining payload bytes
  typedef enum logic [2:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_COLLECT, S_EMIT, S_DRAIN
  } state_t;

  localparam logic [7:0] OPCODE_ADD  = 8'h01;
  localparam logic [7:0] OPCODE_MUL  = 8'h02;
  localparam logic [7:0] OPCODE_DIV  = 8'h03;
  localparam logic [7:0] OPCODE_ECHO = 8'h04;

  state_t       r_state;
  state_t       w_next;
  state_t       w_lenhi_next;
  logic [7:0]   r_opcode;
  logic [7:0]   r_len_lo;
  logic [15:0]  r_cnt;
  logic [31:0]  r_shift;
  logic [1:0]   r_bidx;
  logic         r_first;

  logic [15:0]  w_len;
  logic         w_short;
  logic [15:0]  w_payload;
  logic         w_is_math;
  logic         w_is_echo;
  logic         w_math_ok;
  logic         w_acc;
  logic         w_emit_hs;
  logic         w_emit_last;

  assign w_len     = {rx_data_i, r_len_lo};
  assign w_short   = (w_len < 16'd4);
  // Lengths shorter than the header collapse to an empty payload.
  assign w_payload = w_short ? 16'd0 : (w_len - 16'd4);
  assign w_is_math = (r_opcode == OPCODE_ADD) || (r_opcode == OPCODE_MUL) ||
                     (r_opcode == OPCODE_DIV);
  assign w_is_echo = (r_opcode == OPCODE_ECHO);

  assign w_acc       = rx_valid_i & rx_ready_o;
  assign w_emit_hs   = operand_valid_o & operand_ready_i;
  assign w_emit_last = (r_cnt < 16'd4);

`ifdef ALU_PARSER_ERR_CHECK_EN
  logic w_len_err;
  logic r_err;

  assign w_math_ok = (w_payload[1:0] == 2'b00) && (w_payload <= MAX_PAYLOAD);
  assign w_len_err = w_short || (!w_is_math && !w_is_echo) || (w_is_math && !w_math_ok);
  assign err_o     = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_LEN_HI) && w_acc && w_len_err;
    end
  end
`else
  // Without checking, a math payload with fewer than 4 bytes has nothing to emit.
  assign w_math_ok = (w_payload[15:2] != 14'd0);
  assign err_o     = 1'b0;
`endif

  always_comb begin
    w_lenhi_next = S_DRAIN;
    if (w_payload == 16'd0) begin
      w_lenhi_next = S_IDLE;
    end else if (w_is_echo) begin
      w_lenhi_next = S_ECHO;
    end else if (w_is_math && w_math_ok) begin
      w_lenhi_next = S_COLLECT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_acc) w_next = S_RSVD;
      S_RSVD:    if (w_acc) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_acc) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_acc) w_next = w_lenhi_next;
      S_ECHO:    if (w_acc && (r_cnt <= 16'd1)) w_next = S_IDLE;
      S_COLLECT: if (w_acc && (r_bidx == 2'd3)) w_next = S_EMIT;
      S_EMIT: begin
        if (w_emit_hs) begin
          if (!w_emit_last) w_next = S_COLLECT;
          else if (r_cnt == 16'd0) w_next = S_IDLE;
          else w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 16'd0) w_next = S_IDLE;
        else if (w_acc && (r_cnt == 16'd1)) w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready_o      = 1'b1;
    echo_valid_o    = 1'b0;
    echo_data_o     = 8'h00;
    operand_valid_o = 1'b0;
    operand_first_o = 1'b0;
    operand_last_o  = 1'b0;
    case (r_state)
      S_ECHO: begin
        rx_ready_o   = echo_ready_i;
        echo_valid_o = rx_valid_i;
        echo_data_o  = rx_data_i;
      end
      S_EMIT: begin
        rx_ready_o      = 1'b0;
        operand_valid_o = 1'b1;
        operand_first_o = r_first;
        operand_last_o  = w_emit_last;
      end
      default: rx_ready_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opcode <= 8'h00;
      r_len_lo <= 8'h00;
      r_cnt    <= 16'd0;
      r_shift  <= 32'h0;
      r_bidx   <= 2'd0;
      r_first  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_acc) begin
        r_opcode <= rx_data_i;
      end
      if ((r_state == S_LEN_LO) && w_acc) begin
        r_len_lo <= rx_data_i;
      end
      if ((r_state == S_LEN_HI) && w_acc) begin
        r_cnt   <= w_payload;
        r_first <= 1'b1;
        r_bidx  <= 2'd0;
      end
      if (((r_state == S_ECHO) || (r_state == S_COLLECT) || (r_state == S_DRAIN)) &&
          w_acc && (r_cnt != 16'd0)) begin
        r_cnt <= r_cnt - 16'd1;
      end
      // Little-endian assembly: the first byte shifts down to [7:0] after four bytes.
      if ((r_state == S_COLLECT) && w_acc) begin
        r_shift <= {rx_data_i, r_shift[31:8]};
        r_bidx  <= r_bidx + 2'd1;
      end
      if ((r_state == S_EMIT) && w_emit_hs) begin
        r_first <= 1'b0;
      end
    end
  end

  assign opcode_o  = r_opcode;
  assign operand_o = r_shift;

endmodule

// File: doc/alu_packet_parser.md
ALU_PACKET_PARSER -- requirements
Module: alu_packet_parser

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 16'd1020, the largest accepted payload byte count (length minus 4).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port rx_data_i, input, 8, the byte from the UART receiver.
REQ-005 SHALL have ports rx_valid_i (input, 1) and rx_ready_o (output, 1); a byte transfers when both are high.
REQ-006 SHALL have ports echo_data_o (output, 8), echo_valid_o (output, 1) and echo_ready_i (input, 1); these carry the echo payload bytes to the UART transmitter.
REQ-007 SHALL have port opcode_o, output, 8, the opcode latched for the current packet.
REQ-008 SHALL have ports operand_o (output, 32), operand_valid_o (output, 1) and operand_ready_i (input, 1); these carry the operand stream to the ALU.
REQ-009 SHALL have ports operand_first_o (output, 1) and operand_last_o (output, 1), which mark the first and the last operand of a packet.
REQ-010 SHALL have port err_o, output, 1, a one-cycle error pulse.

Function
REQ-011 SHALL parse the packet format: byte 0 opcode, byte 1 reserved (ignored), bytes 2-3 total length (little-endian, includes the 4 header bytes), then the payload.
REQ-012 SHALL use the FSM states IDLE, RSVD, LEN_LO, LEN_HI, ECHO, COLLECT, EMIT and DRAIN.
REQ-013 SHALL drive rx_ready_o=1 in IDLE, RSVD, LEN_LO, LEN_HI, COLLECT and DRAIN, and rx_ready_o=0 in EMIT.
REQ-014 SHALL make transitions only on accepted bytes: IDLE latches the opcode and goes to RSVD; RSVD goes to LEN_LO; LEN_LO latches len[7:0]; LEN_HI latches len[15:8] and selects the next state per REQ-015.
REQ-015 SHALL select the next state after LEN_HI as follows:
- payload = 0 goes to IDLE;
- OPCODE_ECHO goes to ECHO;
- OPCODE_ADD, OPCODE_MUL and OPCODE_DIV go to COLLECT;
- any other opcode goes to DRAIN.
REQ-016 SHALL make ECHO a combinational pass-through: echo_data_o=rx_data_i, echo_valid_o=rx_valid_i, rx_ready_o=echo_ready_i, with zero-cycle latency.
REQ-017 SHALL have COLLECT assemble 4 bytes little-endian (first byte into [7:0]) and enter EMIT on the 4th byte.
REQ-018 SHALL assert operand_valid_o in EMIT, starting the cycle after the 4th byte is accepted.
REQ-019 SHALL hold operand_o, operand_first_o and operand_last_o stable until operand_ready_i is sampled high.
REQ-020 SHALL leave EMIT on handshake: to IDLE if last, else to COLLECT.
REQ-021 SHALL assert operand_first_o for the first operand of a packet and operand_last_o when the remaining payload is 0.
REQ-022 SHALL count the remaining payload with a 16-bit down-counter, decremented on every accepted payload byte; the counter SHALL never wrap below 0.
REQ-023 SHALL have DRAIN consume and discard payload bytes until the count reaches 0, then go to IDLE.
REQ-024 SHALL pulse err_o (one cycle) on any of these errors:
- unknown opcode: pulse on LEN_HI acceptance;
- math payload not a multiple of 4, or payload > MAX_PAYLOAD: pulse on LEN_HI acceptance, then go to DRAIN;
- length < 4: pulse, then go to IDLE.
REQ-025 SHALL keep opcode_o valid from LEN_HI acceptance until the next IDLE byte is accepted.
REQ-026 SHALL allow back-to-back packets: a byte presented in the cycle after returning to IDLE SHALL be accepted as an opcode.

Reset
REQ-027 SHALL, on rst_ni low, immediately force IDLE and clear all counters, the opcode and the operand shift register.
REQ-028 SHALL reset outputs to: rx_ready_o=1 (IDLE), echo_valid_o=0, operand_valid_o=0, operand_first_o=0, operand_last_o=0, err_o=0, opcode_o=8'h00, operand_o=32'h0.
REQ-029 SHALL discard a packet that is in progress when reset is applied; the first byte accepted after release is an opcode.

Configuration
REQ-030 SHALL support the macro ALU_PARSER_ERR_CHECK_EN.
REQ-031 SHALL, when the macro is defined, implement err_o and the error checks of REQ-024.
REQ-032 SHALL, when the macro is undefined:
- tie err_o to 0;
- send unknown opcodes to DRAIN silently;
- not check multiple-of-4 and MAX_PAYLOAD;
- discard trailing partial bytes of a math payload;
- treat length < 4 as payload 0.

Verification
REQ-033 SHALL cover ADD: bytes [opcode ADD,00,0C,00,01,00,00,00,02,00,00,00] -> operands 0x1 (first) then 0x2 (last), no err_o.
REQ-034 SHALL cover ECHO: bytes [opcode ECHO,00,09,00,"hello"] -> echo bytes 68 65 6C 6C 6F on the same cycles as acceptance, then IDLE.
REQ-035 SHALL cover backpressure: in a DIV packet 0xA,0x2, hold operand_ready_i=0 for 5 cycles -> operand_o=0x0000000A stable and rx_ready_o=0 throughout.
REQ-036 SHALL cover an unknown opcode: opcode 8'hFF with length 6 -> err_o pulses once, 2 payload bytes are drained, and the next packet parses correctly.
REQ-037 SHALL cover a bad MUL length: length 7 -> err_o pulse, 3 bytes drained, no operand_valid_o (macro defined).
REQ-038 SHALL cover reset mid-operation: assert rst_ni low after 2 operand bytes of an ADD -> outputs at reset values; a fresh ADD packet yields correct operands.
